// File: rtl/board_b_rom_loader_if.sv
// Byte-stream source and graphics EPROM download bus for the B-board loader.
interface board_b_rom_loader_if;
  logic        src_valid;
  logic [7:0]  src_data;
  logic        src_ready;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [3:0]  gfx_cs;

  // Loader side: consumes the stream, drives the ioctl port.
  modport master (
    input  src_valid,
    input  src_data,
    output src_ready,
    output ioctl_wr,
    output ioctl_addr,
    output ioctl_dout,
    output gfx_cs
  );

  // Environment side: byte source and EPROM write port.
  modport slave (
    output src_valid,
    output src_data,
    input  src_ready,
    input  ioctl_wr,
    input  ioctl_addr,
    input  ioctl_dout,
    input  gfx_cs
  );
endinterface

// File: rtl/board_b_rom_loader.sv
// Parses HDR / LEN_LO / LEN_HI / data records from a valid/ready byte stream
// and replays the data bytes as paced one-cycle ioctl writes to a gfx region.
module board_b_rom_loader #(
  parameter int unsigned REGION_AW = 15,
  parameter int unsigned WR_GAP    = 3
) (
  input  logic                        sys_clk,
  input  logic                        reset,
  input  logic                        start,
  board_b_rom_loader_if.master        bus,
  output logic                        busy,
  output logic                        done,
  output logic                        error
);

  // Offset is one bit wider than the region so a full 2^REGION_AW record
  // terminates without wrapping; length compares use a common wider width.
  localparam int unsigned OW = REGION_AW + 1;
  localparam int unsigned CW = (OW > 16) ? OW + 1 : 17;
  localparam int unsigned GW = (WR_GAP > 1) ? $clog2(WR_GAP) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_GAP,
    S_DONE,
    S_ERR
  } state_t;

  state_t          r_state;
  logic [1:0]      r_region;
  logic [7:0]      r_len_lo;
  logic [15:0]     r_len;
  logic [OW-1:0]   r_offset;
  logic [GW-1:0]   r_gap;
  logic            r_src_ready;
  logic            r_wr;
  logic [24:0]     r_addr;
  logic [7:0]      r_dout;
  logic [3:0]      r_cs;
  logic            r_busy;
  logic            r_done;
  logic            r_error;

  logic            w_accept;
  logic [15:0]     w_len_in;
  logic            w_len_too_big;
  logic [OW-1:0]   w_next_off;
  logic            w_more;
  logic            w_gap_end;

  assign w_accept      = bus.src_valid & r_src_ready;
  assign w_len_in      = {bus.src_data, r_len_lo};
  assign w_len_too_big = CW'(w_len_in) > (CW'(1) << REGION_AW);
  assign w_next_off    = r_offset + OW'(1);
  assign w_more        = CW'(w_next_off) < CW'(r_len);
  assign w_gap_end     = (r_gap == GW'(WR_GAP - 1));

  // Record parser, write pacing and all registered outputs.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_region    <= '0;
      r_len_lo    <= '0;
      r_len       <= '0;
      r_offset    <= '0;
      r_gap       <= '0;
      r_src_ready <= 1'b0;
      r_wr        <= 1'b0;
      r_addr      <= '0;
      r_dout      <= '0;
      r_cs        <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_wr <= 1'b0;
      unique case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_state     <= S_HDR;
            r_src_ready <= 1'b1;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
          end
        end
        S_HDR: begin
          if (w_accept) begin
            if (bus.src_data[7]) begin
              r_state     <= S_DONE;
              r_src_ready <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
            end else if (|bus.src_data[6:2]) begin
              r_state     <= S_ERR;
              r_src_ready <= 1'b0;
              r_busy      <= 1'b0;
              r_error     <= 1'b1;
            end else begin
              r_region <= bus.src_data[1:0];
              r_state  <= S_LEN_LO;
            end
          end
        end
        S_LEN_LO: begin
          if (w_accept) begin
            r_len_lo <= bus.src_data;
            r_state  <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (w_accept) begin
            r_len <= w_len_in;
            if (w_len_too_big) begin
              r_state     <= S_ERR;
              r_src_ready <= 1'b0;
              r_busy      <= 1'b0;
              r_error     <= 1'b1;
            end else if (w_len_in == 16'd0) begin
              r_state <= S_HDR;
            end else begin
              r_offset <= '0;
              r_cs     <= 4'b0001 << r_region;
              r_state  <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_wr        <= 1'b1;
            r_dout      <= bus.src_data;
            r_addr      <= 25'(r_offset[REGION_AW-1:0]);
            r_src_ready <= 1'b0;
            r_gap       <= '0;
            r_state     <= S_GAP;
          end
        end
        S_GAP: begin
          if (w_gap_end) begin
            r_offset    <= w_next_off;
            r_src_ready <= 1'b1;
            if (w_more) begin
              r_state <= S_DATA;
            end else begin
              r_state <= S_HDR;
              r_cs    <= '0;
            end
          end else begin
            r_gap <= r_gap + GW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.src_ready  = r_src_ready;
  assign bus.ioctl_wr   = r_wr;
  assign bus.ioctl_addr = r_addr;
  assign bus.ioctl_dout = r_dout;
  assign bus.gfx_cs     = r_cs;
  assign busy           = r_busy;
  assign done           = r_done;
  assign error          = r_error;

endmodule

// File: tb/tb_board_b_rom_loader.sv
`timescale 1ns/1ps
module tb_board_b_rom_loader;

  // Region width is scaled down so a full-region record stays short.
  localparam int unsigned AW   = 11;
  localparam int unsigned GAP  = 3;
  localparam int unsigned RLEN = 1 << AW;

  logic sys_clk = 1'b0;
  logic reset   = 1'b1;
  logic start   = 1'b0;
  logic busy;
  logic done;
  logic error;

  board_b_rom_loader_if bus();

  board_b_rom_loader #(
    .REGION_AW (AW),
    .WR_GAP    (GAP)
  ) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .start   (start),
    .bus     (bus),
    .busy    (busy),
    .done    (done),
    .error   (error)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [24:0] addr;
    logic [7:0]  dout;
    logic [3:0]  cs;
  } wr_t;

  wr_t         exp_q[$];
  int unsigned wr_cyc[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned cyc = 0;
  int unsigned last_wr = 0;
  bit          have_last = 1'b0;
  wr_t         mon_got;
  wr_t         mon_want;

  // Monitor: every write strobe pops one expected write and checks pacing.
  initial begin
    forever begin
      @(negedge sys_clk);
      cyc++;
      if (bus.ioctl_wr === 1'b1) begin
        mon_got = {bus.ioctl_addr, bus.ioctl_dout, bus.gfx_cs};
        wr_cyc.push_back(cyc);
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_write: got addr=%h dout=%h cs=%b, required no write",
                   mon_got.addr, mon_got.dout, mon_got.cs);
        end else begin
          mon_want = exp_q.pop_front();
          if (mon_got !== mon_want) begin
            n_bad++;
            $display("FAIL write: got addr=%h dout=%h cs=%b, required addr=%h dout=%h cs=%b",
                     mon_got.addr, mon_got.dout, mon_got.cs,
                     mon_want.addr, mon_want.dout, mon_want.cs);
          end
        end
        if (have_last) begin
          n_cmp++;
          if (cyc - last_wr < GAP + 1) begin
            n_bad++;
            $display("FAIL wr_spacing: got %0d cycles, required >= %0d", cyc - last_wr, GAP + 1);
          end
        end
        last_wr   = cyc;
        have_last = 1'b1;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  task automatic send(input logic [7:0] b, input bit stall);
    int unsigned t;
    t = 0;
    bus.src_data = b;
    forever begin
      @(negedge sys_clk);
      bus.src_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.src_valid && bus.src_ready) break;
      t++;
      if (t > 1000) begin
        n_cmp++;
        n_bad++;
        $display("FAIL send_timeout: byte %h not accepted, required accept within 1000 cycles", b);
        bus.src_valid = 1'b0;
        return;
      end
    end
    @(posedge sys_clk);
    #1;
    bus.src_valid = 1'b0;
  endtask

  task automatic send_data(input logic [7:0] b, input logic [24:0] addr,
                           input logic [3:0] cs, input bit stall);
    exp_q.push_back({addr, b, cs});
    send(b, stall);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic status(input string name, input logic b, input logic d, input logic e);
    @(negedge sys_clk);
    check(name, 64'({busy, done, error}), 64'({b, d, e}));
  endtask

  initial begin
    bus.src_valid = 1'b0;
    bus.src_data  = '0;

    // Reset, with start asserted on the last reset cycle.
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    reset = 1'b0;
    @(negedge sys_clk);
    check("reset_outputs",
          64'({busy, done, error, bus.src_ready, bus.ioctl_wr, bus.gfx_cs, bus.ioctl_addr, bus.ioctl_dout}),
          64'd0);
    tick();
    @(negedge sys_clk);
    check("start_with_reset_ignored", 64'({busy, bus.src_ready}), 64'd0);

    // Basic record 01 03 00 AA BB CC 80, with a start pulse while busy.
    tick();
    pulse_start();
    @(negedge sys_clk);
    check("start_to_hdr", 64'({busy, bus.src_ready}), 64'b11);
    send(8'h01, 1'b0);
    start = 1'b1;
    send(8'h03, 1'b0);
    start = 1'b0;
    send(8'h00, 1'b0);
    wr_cyc.delete();
    send_data(8'hAA, 25'd0, 4'b0010, 1'b0);
    send_data(8'hBB, 25'd1, 4'b0010, 1'b0);
    send_data(8'hCC, 25'd2, 4'b0010, 1'b0);
    send(8'h80, 1'b0);
    status("basic_done", 1'b0, 1'b1, 1'b0);
    check("basic_idle_bus", 64'({bus.ioctl_wr, bus.gfx_cs, bus.src_ready}), 64'd0);
    check("basic_hold", 64'({bus.ioctl_addr, bus.ioctl_dout}), 64'({25'd2, 8'hCC}));
    check("basic_wr_count", 64'(wr_cyc.size()), 64'd3);
    if (wr_cyc.size() == 3) begin
      check("basic_spacing_0", 64'(wr_cyc[1] - wr_cyc[0]), 64'(GAP + 1));
      check("basic_spacing_1", 64'(wr_cyc[2] - wr_cyc[1]), 64'(GAP + 1));
    end

    // Malformed header.
    tick();
    pulse_start();
    send(8'h04, 1'b0);
    status("err_hdr", 1'b0, 1'b0, 1'b1);
    check("err_hdr_ready", 64'(bus.src_ready), 64'd0);

    // Length 0x8001 exceeds the region.
    tick();
    pulse_start();
    send(8'h00, 1'b0);
    send(8'h01, 1'b0);
    send(8'h80, 1'b0);
    status("err_len_8001", 1'b0, 1'b0, 1'b1);
    check("err_len_8001_cs", 64'(bus.gfx_cs), 64'd0);

    // Length one past the region size.
    tick();
    pulse_start();
    send(8'h00, 1'b0);
    send(8'h01, 1'b0);
    send(8'(RLEN >> 8), 1'b0);
    status("err_len_boundary", 1'b0, 1'b0, 1'b1);

    // Empty record, then end marker.
    tick();
    pulse_start();
    status("err_cleared_by_start", 1'b1, 1'b0, 1'b0);
    send(8'h02, 1'b0);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    check("empty_cs", 64'(bus.gfx_cs), 64'd0);
    send(8'h80, 1'b0);
    status("empty_done", 1'b0, 1'b1, 1'b0);

    // Record with a randomly stalling source.
    tick();
    pulse_start();
    send(8'h01, 1'b1);
    send(8'h05, 1'b1);
    send(8'h00, 1'b1);
    for (int unsigned i = 0; i < 5; i++) begin
      send_data(8'h30 + 8'(i), 25'(i), 4'b0010, 1'b1);
    end
    send(8'h80, 1'b1);
    status("stall_done", 1'b0, 1'b1, 1'b0);

    // Full region into region 3.
    tick();
    pulse_start();
    send(8'h03, 1'b0);
    send(8'h00, 1'b0);
    send(8'(RLEN >> 8), 1'b0);
    for (int unsigned i = 0; i < RLEN; i++) begin
      send_data(8'(i), 25'(i), 4'b1000, 1'b0);
    end
    send(8'h80, 1'b0);
    status("full_done", 1'b0, 1'b1, 1'b0);
    check("full_last_hold", 64'({bus.ioctl_addr, bus.ioctl_dout}), 64'({25'(RLEN - 1), 8'hFF}));
    check("full_queue_drained", 64'(exp_q.size()), 64'd0);

    // Reset in the GAP after 5 of 10 bytes.
    tick();
    pulse_start();
    send(8'h00, 1'b0);
    send(8'h0A, 1'b0);
    send(8'h00, 1'b0);
    for (int unsigned i = 0; i < 5; i++) begin
      send_data(8'h50 + 8'(i), 25'(i), 4'b0001, 1'b0);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge sys_clk);
    check("reset_mid_data", 64'({bus.ioctl_wr, bus.gfx_cs, busy, bus.src_ready}), 64'd0);
    check("reset_queue_drained", 64'(exp_q.size()), 64'd0);

    tick();
    pulse_start();
    send(8'h00, 1'b0);
    send(8'h0A, 1'b0);
    send(8'h00, 1'b0);
    for (int unsigned i = 0; i < 10; i++) begin
      send_data(8'h60 + 8'(i), 25'(i), 4'b0001, 1'b0);
    end
    send(8'h80, 1'b0);
    status("rewrite_done", 1'b0, 1'b1, 1'b0);

    repeat (5) tick();
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
